x_bit_arb_mux: RTL and testbench
================================

// Module: x_bit_arb_mux
// PURPOSE
//  Parametrised N-input, WIDTH-bit arbitrated mux with valid/ready handshake and one registered output stage.
//  Replaces fixed 8:1 select-driven muxes wherever several producers share one consumer (e.g. writeback/bus sharing).
//  Picks one requesting input per cycle, using round-robin or fixed priority.
//  Registers the winning data and the winner's index, and holds both stable under output backpressure.
// PARAMETERS
//  WIDTH    16  data width per channel, >=1
//  NUM_IN   8   number of input channels, >=1 (need not be a power of two)
//  RR_MODE  1   1 = round-robin priority, 0 = fixed priority (lowest index wins)
//  SEL_W    derived = max(1, clog2(NUM_IN)); localparam, not overridable
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  in_valid   in   NUM_IN         per-channel request
//  in_data    in   NUM_IN*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  in_ready   out  NUM_IN         one-hot or zero; beat i transfers when in_valid[i] & in_ready[i]
//  out_valid  out  1              registered output beat present
//  out_data   out  WIDTH          registered data of the winning channel
//  out_sel    out  SEL_W          registered index of the winning channel
//  out_ready  in   1              consumer accepts; beat transfers when out_valid & out_ready
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, rr pointer=0. in_ready is combinational.
//  - Reset mid-operation discards any held beat; no beat is ever duplicated.
//  - load = ~out_valid | out_ready. This is the only combinational path from out_ready (it feeds in_ready).
//  - Arbitration is combinational over in_valid and yields grant index g and any_req.
//  - in_ready[g] = load & any_req; all other in_ready bits are 0.
//  - Edge with load & any_req: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
//  - Edge with load & ~any_req: out_valid <= 0; out_data and out_sel hold their values.
//  - Edge with ~load: all output registers hold; data and index stay stable until accepted.
//  - Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle with out_ready held at 1.
//  - Round-robin: search starts at pointer p and scans p, p+1, ..., NUM_IN-1, 0, ..., p-1; first set bit wins.
//  - Pointer update: on each input transfer, p <= (g==NUM_IN-1) ? 0 : g+1. Otherwise p holds.
//  - Fairness: with all channels requesting continuously, each is granted exactly once per NUM_IN transfers.
//  - Fixed priority (RR_MODE=0): lowest set index wins; the pointer is unused and tied to 0.
//  - Simultaneous out accept and new grant in the same cycle: replace the output beat; no bubble.
//  - NUM_IN=1: in_ready[0]=load, out_sel is constant 0, and the block degenerates to a one-entry pipe register.
//  - in_valid deasserted before being granted: legal. The channel simply drops out of arbitration.
//  - Input data is sampled only on a transfer edge; in_data of non-granted channels is don't-care.
// STRUCTURE
//  - Shared header (risky_defs.vh, pulled in with `include): CLOG2 macro, ARB_RR=1 / ARB_FIXED=0 constants.
//  - Sub-module rr_arbiter #(NUM_IN, RR_MODE): in req, adv, clk, rst; out grant_idx, any_req.
//    It owns the pointer; adv = load & any_req.
//  - Top level: generate-loop slice extraction, registered output stage, and in_ready decode.
// TESTING
//  1. Reset with out_ready=0, then in_valid=8'h04 and in_data[2]=16'hBEEF
//     -> in_ready=8'h04 for 1 cycle; next cycle out_valid=1, out_data=BEEF, out_sel=2.
//  2. RR_MODE=1, in_valid=8'hFF held, out_ready=1
//     -> out_sel sequence 0,1,2,...,7,0 with one beat per cycle and no gaps.
//  3. Backpressure: out_valid=1 with out_sel=3, then out_ready=0 for 5 cycles
//     -> out_data/out_sel stable and in_ready=0; beat advances on the cycle out_ready=1.
//  4. RR_MODE=1 with pointer at 7 and in_valid=8'h81
//     -> grant 7 and pointer becomes 0; next grant is 0; confirms wrap-around.
//  5. RR_MODE=0 with in_valid=8'h90 held
//     -> every grant is 4 and channel 7 is starved (fixed-priority check).
//  6. Assert rst while out_valid=1 and out_ready=0
//     -> out_valid=0 immediately (async); after release, first grant follows pointer=0 order.
//  Bench-wide scoreboard: every input transfer appears exactly once at the output, in order.
//  Also run NUM_IN=1 and NUM_IN=5 (non-power-of-two) variants of tests 1-3.

Source files
------------

// File: rtl/x_bit_arb_mux_pkg.sv
// Shared types and helpers for the arbitrated mux and its arbiter.
// Priority-mode constants, select-width derivation and modular index stepping.
package x_bit_arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int sel_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // base + off folded back into 0..n-1; off is always below n
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/x_bit_arb_mux_rr_arbiter.sv
// Combinational request arbiter with a rotating priority pointer.
// Fixed-priority mode keeps the pointer at 0 so the lowest index always wins.
module x_bit_arb_mux_rr_arbiter
  import x_bit_arb_mux_pkg::*;
#(
  parameter int  NUM_IN  = 8,
  parameter int  RR_MODE = ARB_RR,
  localparam int SEL_W   = sel_width(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              adv,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_req
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] ptr_nxt_s;
  logic [SEL_W-1:0] start_s;
  logic [SEL_W-1:0] cand_s;
  logic             found_s;

  assign any_req   = |req;
  assign start_s   = (RR_MODE == ARB_RR) ? ptr_r : '0;
  assign ptr_nxt_s = (grant_idx == LAST_IDX) ? '0 : (grant_idx + SEL_W'(32'd1));

  // Scan p, p+1, ..., wrapping, and take the first requester
  always_comb begin
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      cand_s = SEL_W'(wrap_add(int'(start_s), j, NUM_IN));
      if (!found_s && req[cand_s]) begin
        grant_idx = cand_s;
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Pointer moves just past the winner on every transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (adv && (RR_MODE == ARB_RR)) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/x_bit_arb_mux.sv
// N-input arbitrated mux: grants one requesting channel per cycle and registers its
// data and index in a single output stage that holds stable under backpressure.
module x_bit_arb_mux
  import x_bit_arb_mux_pkg::*;
#(
  parameter int  WIDTH   = 16,
  parameter int  NUM_IN  = 8,
  parameter int  RR_MODE = ARB_RR,
  localparam int SEL_W   = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] slice_s [NUM_IN];
  logic [SEL_W-1:0] grant_s;
  logic             any_req_s;
  logic             load_s;
  logic             adv_s;
  out_state_e       state_r, state_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic [SEL_W-1:0] sel_r, sel_s;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_slice
    assign slice_s[i] = in_data[i*WIDTH +: WIDTH];
  end

  // out_ready reaches in_ready only through load_s
  assign load_s = (state_r == OUT_EMPTY) | out_ready;
  assign adv_s  = load_s & any_req_s;

  x_bit_arb_mux_rr_arbiter #(
    .NUM_IN  (NUM_IN),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .adv       (adv_s),
    .grant_idx (grant_s),
    .any_req   (any_req_s)
  );

  // One-hot ready to the winner, only when the output stage can take a beat
  always_comb begin
    in_ready = '0;
    if (adv_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output stage: load a new beat, drain to empty, or hold under backpressure
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    sel_s   = sel_r;
    case (state_r)
      OUT_EMPTY: begin
        if (any_req_s) begin
          state_s = OUT_FULL;
          data_s  = slice_s[grant_s];
          sel_s   = grant_s;
        end else begin
          state_s = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        if (adv_s) begin
          state_s = OUT_FULL;
          data_s  = slice_s[grant_s];
          sel_s   = grant_s;
        end else if (out_ready) begin
          state_s = OUT_EMPTY;
        end else begin
          state_s = OUT_FULL;
        end
      end
      default: begin
        state_s = OUT_EMPTY;
      end
    endcase
  end

  // Output registers; reset discards any held beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= OUT_EMPTY;
      data_r  <= '0;
      sel_r   <= '0;
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      sel_r   <= sel_s;
    end
  end

  assign out_valid = (state_r == OUT_FULL);
  assign out_data  = data_r;
  assign out_sel   = sel_r;

endmodule

// File: tb/tb_x_bit_arb_mux.sv
// Bench for x_bit_arb_mux: four variants (8 RR, 8 fixed, 5 RR, 1 channel) share one stimulus
// and are checked every cycle against an arbitration model plus a per-variant beat scoreboard.
module tb_x_bit_arb_mux;

  localparam int NI = 4;
  localparam int W  = 16;
  localparam int NCH [NI] = '{8, 8, 5, 1};
  localparam int RRM [NI] = '{1, 0, 1, 1};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         out_ready;
  logic [7:0]   in_valid;
  logic [127:0] in_data;
  logic         chk_en;

  logic        ov_a, ov_b, ov_c, ov_d;
  logic [15:0] od_a, od_b, od_c, od_d;
  logic [2:0]  os_a, os_b, os_c;
  logic [0:0]  os_d;
  logic [7:0]  ir_a, ir_b;
  logic [4:0]  ir_c;
  logic [0:0]  ir_d;

  logic [3:0]  ov;
  logic [15:0] od [NI];
  logic [2:0]  os [NI];
  logic [7:0]  ir [NI];

  assign ov    = {ov_d, ov_c, ov_b, ov_a};
  assign od[0] = od_a;  assign od[1] = od_b;  assign od[2] = od_c;  assign od[3] = od_d;
  assign os[0] = os_a;  assign os[1] = os_b;  assign os[2] = os_c;  assign os[3] = {2'b00, os_d};
  assign ir[0] = ir_a;  assign ir[1] = ir_b;  assign ir[2] = {3'b000, ir_c};  assign ir[3] = {7'b0000000, ir_d};

  x_bit_arb_mux #(.WIDTH(W), .NUM_IN(8), .RR_MODE(1)) u_rr8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_a),
    .out_valid(ov_a), .out_data(od_a), .out_sel(os_a), .out_ready(out_ready));
  x_bit_arb_mux #(.WIDTH(W), .NUM_IN(8), .RR_MODE(0)) u_fx8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_b),
    .out_valid(ov_b), .out_data(od_b), .out_sel(os_b), .out_ready(out_ready));
  x_bit_arb_mux #(.WIDTH(W), .NUM_IN(5), .RR_MODE(1)) u_rr5 (
    .clk(clk), .rst(rst), .in_valid(in_valid[4:0]), .in_data(in_data[79:0]), .in_ready(ir_c),
    .out_valid(ov_c), .out_data(od_c), .out_sel(os_c), .out_ready(out_ready));
  x_bit_arb_mux #(.WIDTH(W), .NUM_IN(1), .RR_MODE(1)) u_one (
    .clk(clk), .rst(rst), .in_valid(in_valid[0:0]), .in_data(in_data[15:0]), .in_ready(ir_d),
    .out_valid(ov_d), .out_data(od_d), .out_sel(os_d), .out_ready(out_ready));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s inst=%0d got=%0h exp=%0h @%0t", name, k, got, exp, $time);
  endtask

  // model state (registered view) and its predicted next value
  logic        mv [NI];
  logic [15:0] md [NI];
  int          ms [NI];
  int          mp [NI];
  logic        nv [NI];
  logic [15:0] nd [NI];
  int          ns [NI];
  int          np [NI];

  logic [15:0] sb [NI][64];
  int          sb_wr [NI];
  int          sb_rd [NI];

  int          c_n, c_g, c_st;
  logic [7:0]  c_req, c_exp;
  logic        c_load, c_any;

  initial begin
    for (int k = 0; k < NI; k++) begin
      sb_wr[k] = 0;
      sb_rd[k] = 0;
    end
  end

  // Reference model: outputs, in_ready and beat order predicted from the arbitration rules
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      c_n    = NCH[k];
      c_req  = in_valid & ((8'd1 << c_n) - 8'd1);
      c_load = !mv[k] || out_ready;
      c_any  = (c_req != 8'd0);
      c_st   = (RRM[k] != 0) ? mp[k] : 0;
      c_g    = -1;
      for (int j = 0; j < c_n; j++)
        if (c_g < 0 && c_req[(c_st + j) % c_n]) c_g = (c_st + j) % c_n;
      c_exp  = (c_load && c_any) ? (8'd1 << c_g) : 8'd0;
      nv[k] = mv[k]; nd[k] = md[k]; ns[k] = ms[k]; np[k] = mp[k];
      if (rst) begin
        sb_rd[k] = sb_wr[k];
      end else if (chk_en) begin
        check("in_ready", k, {24'd0, ir[k]}, {24'd0, c_exp});
        check("out_valid", k, {31'd0, ov[k]}, {31'd0, mv[k]});
        check("out_data", k, {16'd0, od[k]}, {16'd0, md[k]});
        check("out_sel", k, {29'd0, os[k]}, ms[k]);
        if (mv[k] && out_ready) begin
          if (sb_rd[k] == sb_wr[k]) check("sb_empty", k, 32'd0, 32'd1);
          else check("sb_order", k, {16'd0, od[k]}, {16'd0, sb[k][sb_rd[k] % 64]});
          sb_rd[k]++;
        end
        if (c_load && c_any) begin
          nv[k] = 1'b1;
          nd[k] = in_data[c_g*W +: W];
          ns[k] = c_g;
          np[k] = (RRM[k] != 0) ? ((c_g == c_n - 1) ? 0 : c_g + 1) : 0;
          sb[k][sb_wr[k] % 64] = nd[k];
          sb_wr[k]++;
        end else if (c_load) begin
          nv[k] = 1'b0;
        end
      end
    end
  end

  // Model register update, reset asynchronously like the design
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        mv[k] <= 1'b0; md[k] <= 16'd0; ms[k] <= 0; mp[k] <= 0;
      end else begin
        mv[k] <= nv[k]; md[k] <= nd[k]; ms[k] <= ns[k]; mp[k] <= np[k];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    chk_en = 1'b0; out_ready = 1'b1; in_valid = 8'h00; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 0, {31'd0, ov[0]}, 32'd0);
    check("rst_data", 0, {16'd0, od[0]}, 32'd0);
    check("rst_sel", 0, {29'd0, os[0]}, 32'd0);

    // all channels requesting: 0..7 then 0, one beat per cycle
    step(); in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("t2_valid", 0, {31'd0, ov[0]}, 32'd1);
        check("t2_sel", 0, {29'd0, os[0]}, (i - 1) % 8);
      end
      step();
    end
    in_valid = 8'h00;
    @(negedge clk); step();

    // single request with the consumer stalled
    out_ready = 1'b0; in_valid = 8'h04; in_data[32 +: 16] = 16'hBEEF;
    @(negedge clk);
    check("t1_ready", 0, {24'd0, ir[0]}, 32'h04);
    step(); in_valid = 8'h00;
    @(negedge clk);
    check("t1_valid", 0, {31'd0, ov[0]}, 32'd1);
    check("t1_data", 0, {16'd0, od[0]}, 32'hBEEF);
    check("t1_sel", 0, {29'd0, os[0]}, 32'd2);
    check("t1_ready_off", 0, {24'd0, ir[0]}, 32'h00);

    // backpressure holds a beat from channel 3
    step(); out_ready = 1'b1; in_valid = 8'h08; in_data[48 +: 16] = 16'hCAFE;
    @(negedge clk);
    check("t3_grant", 0, {24'd0, ir[0]}, 32'h08);
    step(); out_ready = 1'b0; in_valid = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_data", 0, {16'd0, od[0]}, 32'hCAFE);
      check("t3_hold_sel", 0, {29'd0, os[0]}, 32'd3);
      check("t3_hold_ready", 0, {24'd0, ir[0]}, 32'h00);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_release", 0, {24'd0, ir[0]}, 32'h10);
    step();
    @(negedge clk);
    check("t3_next_sel", 0, {29'd0, os[0]}, 32'd4);

    // pointer wrap: grant 6 moves pointer to 7, then 7 then 0
    step(); in_valid = 8'h40;
    @(negedge clk);
    check("t4_g6", 0, {24'd0, ir[0]}, 32'h40);
    step(); in_valid = 8'h81;
    @(negedge clk);
    check("t4_g7", 0, {24'd0, ir[0]}, 32'h80);
    step();
    @(negedge clk);
    check("t4_g0", 0, {24'd0, ir[0]}, 32'h01);
    check("t4_sel7", 0, {29'd0, os[0]}, 32'd7);

    // fixed priority starves channel 7
    step(); in_valid = 8'h90;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_ready", 1, {24'd0, ir[1]}, 32'h10);
      if (i > 0) check("t5_sel", 1, {29'd0, os[1]}, 32'd4);
      step();
    end

    // reset while a beat is held
    in_valid = 8'h01;
    @(negedge clk); step();
    out_ready = 1'b0; in_valid = 8'h00;
    @(negedge clk); step();
    #3 rst = 1'b1;
    #1 check("t6_async", 0, {28'd0, ov}, 32'd0);
    check("t6_async_data", 0, {16'd0, od[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    check("t6_first_grant", 0, {24'd0, ir[0]}, 32'h01);
    step();
    @(negedge clk);
    check("t6_first_sel", 0, {29'd0, os[0]}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      in_valid  = (i % 3 == 0) ? 8'($urandom) & 8'($urandom) : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
